uart_receiver: RTL

- Serial receive path of the APB UART; the receive-side counterpart of the transmitter's frame and parity generation.
- Oversamples the line using the baud-rate tick and deserialises LSB-first 8-bit frames.
- Checks the optional parity bit and the stop bit.
- Presents each received byte with a one-cycle valid strobe and per-frame error flags to the register/FIFO layer.

---
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// Oversampling UART receive path: LSB-first frames with optional parity and stop-bit checking.
// Optional feature: define UART_RX_BREAK_EN to add the break_o line-break indicator.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_tick_i,
    input  logic                  rx_i,
    input  logic                  parity_en_i,
    input  logic                  parity_type_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  busy_o
`ifdef UART_RX_BREAK_EN
    ,
    output logic                  break_o
`endif
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_reg;
    logic                    rx_meta_reg;
    logic                    rx_s_reg;
    logic                    rx_prev_reg;
    logic [TW-1:0]           tick_cnt_reg;
    logic [BW-1:0]           bit_cnt_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_en_reg;
    logic                    par_type_reg;
    logic                    par_err_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    valid_reg;
    logic                    parity_err_reg;
    logic                    frame_err_reg;
    logic                    busy_reg;
    logic                    expected_par_bit;
`ifdef UART_RX_BREAK_EN
    logic                    par_bit_reg;
    logic                    break_reg;
`endif

    // Even parity: bit equals XOR of data; odd parity: its complement.
    assign expected_par_bit = par_type_reg ? (^shift_reg) : (~^shift_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rx_meta_reg    <= 1'b1;
            rx_s_reg       <= 1'b1;
            rx_prev_reg    <= 1'b1;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            par_en_reg     <= 1'b0;
            par_type_reg   <= 1'b0;
            par_err_reg    <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef UART_RX_BREAK_EN
            par_bit_reg    <= 1'b0;
            break_reg      <= 1'b0;
`endif
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
            valid_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    busy_reg <= 1'b0;
                    // Only a genuine 1->0 transition arms a frame, so a stuck-low line stays idle.
                    if (rx_prev_reg && !rx_s_reg) begin
                        state_reg    <= ST_START;
                        tick_cnt_reg <= '0;
                        par_en_reg   <= parity_en_i;
                        par_type_reg <= parity_type_i;
                        busy_reg     <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        par_bit_reg  <= 1'b0;
`endif
                    end
                end

                ST_START: begin
                    if (baud_tick_i) begin
                        if (tick_cnt_reg == TICK_HALF) begin
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= rx_s_reg ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (baud_tick_i) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rx_s_reg, shift_reg[DATA_WIDTH-1:1]};
                            if (bit_cnt_reg == BIT_LAST) begin
                                state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (baud_tick_i) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg <= '0;
                            par_err_reg  <= (rx_s_reg != expected_par_bit);
`ifdef UART_RX_BREAK_EN
                            par_bit_reg  <= rx_s_reg;
`endif
                            state_reg    <= ST_STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (baud_tick_i) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg   <= '0;
                            data_reg       <= shift_reg;
                            parity_err_reg <= par_en_reg & par_err_reg;
                            frame_err_reg  <= ~rx_s_reg;
                            valid_reg      <= 1'b1;
`ifdef UART_RX_BREAK_EN
                            break_reg      <= (shift_reg == '0) && !rx_s_reg &&
                                              (!par_en_reg || !par_bit_reg);
`endif
                            state_reg      <= ST_IDLE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign parity_err_o = parity_err_reg;
    assign frame_err_o  = frame_err_reg;
    assign busy_o       = busy_reg;
`ifdef UART_RX_BREAK_EN
    assign break_o      = break_reg;
`endif

endmodule
